red_pitaya_bus_master: RTL and testbench
========================================

RED_PITAYA_BUS_MASTER -- requirements
Module: red_pitaya_bus_master

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, the number of WAIT cycles allowed without sys_ack_i before the transaction is aborted.
REQ-002 SHALL provide parameter CMD_DEPTH, default 4, the command FIFO depth; it SHALL be a power of two.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
- clk_i  in  1  processing clock.
- rstn_i  in  1  asynchronous reset, active low.
- cmd_valid_i  in  1  a command is offered.
- cmd_ready_o  out  1  the FIFO can accept a command.
- cmd_write_i  in  1  1 = register write, 0 = register read.
- cmd_addr_i  in  32  target bus address.
- cmd_wdata_i  in  32  write data; ignored for reads.
- rsp_valid_o  out  1  a response is available.
- rsp_ready_i  in  1  the consumer accepts the response.
- rsp_rdata_o  out  32  captured read data; 0 for writes and timeouts.
- rsp_err_o  out  1  the responder signalled sys_err_i with its ack.
- rsp_timeout_o  out  1  no ack arrived within TIMEOUT cycles.
- sys_addr_o  out  32  bus address.
- sys_wdata_o  out  32  bus write data.
- sys_sel_o  out  4  byte select; constant 4'hF.
- sys_wen_o  out  1  write strobe.
- sys_ren_o  out  1  read strobe.
- sys_rdata_i  in  32  responder read data.
- sys_err_i  in  1  responder error.
- sys_ack_i  in  1  responder acknowledge.
- busy_o  out  1  high when state != IDLE or the FIFO is non-empty.

Function
REQ-004 SHALL buffer commands {write, addr, wdata} in a CMD_DEPTH-entry FIFO.
- A push occurs on cmd_valid_i & cmd_ready_o.
- cmd_ready_o = !full.
- When full, no push is accepted, even if a pop occurs in the same cycle.
REQ-005 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-006 IDLE: if the FIFO is non-empty, pop the head entry, register it into sys_addr_o, sys_wdata_o and the op bit, and go to ISSUE; otherwise stay in IDLE.
REQ-007 ISSUE: assert exactly one of sys_wen_o/sys_ren_o (per the op bit) for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-008 SHALL treat sys_ack_i as meaningful only in WAIT; an ack during IDLE, ISSUE or RESP SHALL be ignored.
REQ-009 WAIT: on the first cycle with sys_ack_i = 1, do the following, then go to RESP.
- Capture sys_err_i into rsp_err_o.
- Capture sys_rdata_i into rsp_rdata_o for reads; capture 0 for writes.
- Clear rsp_timeout_o.
REQ-010 WAIT: on the TIMEOUT-th consecutive WAIT cycle without ack, set rsp_timeout_o = 1, rsp_err_o = 0 and rsp_rdata_o = 0, then go to RESP.
- An ack arriving in that same cycle SHALL take priority over the timeout.
REQ-011 RESP: hold rsp_valid_o = 1 with all rsp_* fields stable until rsp_ready_i = 1, then go to IDLE.
- rsp_valid_o SHALL be 0 in every other state.
REQ-012 sys_addr_o and sys_wdata_o SHALL hold their values from ISSUE until the next pop; strobes SHALL be 0 outside ISSUE.
REQ-013 Latency: a command handshaken in cycle k into an empty FIFO while in IDLE SHALL produce its strobe in cycle k+2. An ack in cycle m SHALL produce rsp_valid_o from cycle m+1.
REQ-014 SHALL have at most one outstanding transaction; the next strobe occurs no earlier than 2 cycles after the response handshake.
REQ-015 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL NOT wrap.

Reset
REQ-016 While rstn_i = 0, asynchronously and immediately, the block SHALL:
- set state to IDLE and empty the FIFO;
- drive sys_wen_o, sys_ren_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, cmd_ready_o and busy_o to 0;
- drive sys_addr_o, sys_wdata_o and rsp_rdata_o to 0;
- keep sys_sel_o at 4'hF.
REQ-017 Reset asserted mid-transaction SHALL discard the transaction and all queued commands with no response.
- cmd_ready_o = 1 on the first clock edge after release.

Verification
REQ-018 Write: addr 0x40300004, wdata 0x2, ack with err=0 one cycle after the strobe -> sys_wen_o high exactly one cycle with matching addr/wdata; response rdata=0, err=0, timeout=0.
REQ-019 Read: addr 0x40350000; responder returns 0x0000000A with ack 2 cycles after the strobe -> sys_ren_o high one cycle; rsp_rdata_o=0xA.
REQ-020 Timeout with TIMEOUT=16 and no ack -> a single strobe; rsp_timeout_o=1 with rsp_valid_o rising after 16 WAIT cycles; rdata=0; an ack arriving later is ignored.
REQ-021 Backpressure: responder stalled and rsp_ready_i=0; offer 6 back-to-back commands -> 5 accepted (1 in flight + 4 queued), then cmd_ready_o=0; the response stays stable while rsp_ready_i=0; all 5 complete in order.
REQ-022 Error: ack with sys_err_i=1 on a read -> rsp_err_o=1, rsp_rdata_o=sys_rdata_i.
REQ-023 Reset in WAIT with 2 commands queued -> all outputs zero immediately, no response; after release busy_o=0 and cmd_ready_o=1.

Source files
------------

// File: rtl/red_pitaya_bus_master.sv
// rtl/red_pitaya_bus_master.sv - queued single-outstanding register bus master with ack timeout
module red_pitaya_bus_master #(
    parameter int TIMEOUT   = 16,
    parameter int CMD_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [31:0] sys_addr_o,
    output logic [31:0] sys_wdata_o,
    output logic [3:0]  sys_sel_o,
    output logic        sys_wen_o,
    output logic        sys_ren_o,
    input  logic [31:0] sys_rdata_i,
    input  logic        sys_err_i,
    input  logic        sys_ack_i,
    output logic        busy_o
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state_q, state_d;

    logic [64:0]   fifo_mem [CMD_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;
    logic          hd_write;
    logic [31:0]   hd_addr, hd_wdata;

    logic          op_write_q;
    logic [31:0]   addr_q, wdata_q;
    logic [CW-1:0] cnt_q;
    logic          cnt_clr, cnt_inc, cap_ack, cap_to;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q, rsp_timeout_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready_o = rstn_i & ~full;
    assign push = cmd_valid_i & cmd_ready_o;
    assign {hd_write, hd_addr, hd_wdata} = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        cap_ack = 1'b0;
        cap_to  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (sys_ack_i) begin
                    cap_ack = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cap_to  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (pop) begin
                op_write_q <= hd_write;
                addr_q     <= hd_addr;
                wdata_q    <= hd_wdata;
            end
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
            if (cap_ack) begin
                rsp_err_q     <= sys_err_i;
                rsp_rdata_q   <= op_write_q ? 32'h0 : sys_rdata_i;
                rsp_timeout_q <= 1'b0;
            end else if (cap_to) begin
                rsp_err_q     <= 1'b0;
                rsp_rdata_q   <= 32'h0;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign sys_addr_o    = addr_q;
    assign sys_wdata_o   = wdata_q;
    assign sys_sel_o     = 4'hF;
    assign sys_wen_o     = (state_q == ISSUE) &  op_write_q;
    assign sys_ren_o     = (state_q == ISSUE) & ~op_write_q;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_red_pitaya_bus_master.sv
// tb/tb_red_pitaya_bus_master.sv - directed self-checking bench for red_pitaya_bus_master
module tb_red_pitaya_bus_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata = '0;
    logic        sys_err = 1'b0;
    logic        sys_ack = 1'b0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    red_pitaya_bus_master #(.TIMEOUT(16), .CMD_DEPTH(4)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .sys_addr_o   (sys_addr),
        .sys_wdata_o  (sys_wdata),
        .sys_sel_o    (sys_sel),
        .sys_wen_o    (sys_wen),
        .sys_ren_o    (sys_ren),
        .sys_rdata_i  (sys_rdata),
        .sys_err_i    (sys_err),
        .sys_ack_i    (sys_ack),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Offers one command at a negedge; returns at the following negedge.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({sys_wen, sys_ren, rsp_valid, rsp_err, rsp_timeout, cmd_ready, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {sys_wen, sys_ren, rsp_valid, rsp_err, rsp_timeout, cmd_ready, busy});
        end
        vectors++;
        if ({sys_addr, sys_wdata, rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {sys_addr, sys_wdata, rsp_rdata});
        end
        vectors++;
        if (sys_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_sel: got %h expected f", sys_sel);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_ready_busy: got %b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write();
        push(1'b1, 32'h40300004, 32'h2);
        vectors++;
        if ({sys_wen, sys_ren} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_early_strobe: got %b expected 00", {sys_wen, sys_ren});
        end
        @(negedge clk);
        vectors++;
        if ({sys_wen, sys_ren, sys_addr, sys_wdata} !== {2'b10, 32'h40300004, 32'h2}) begin
            miscompares++;
            $display("FAIL write_strobe: got %h expected %h",
                     {sys_wen, sys_ren, sys_addr, sys_wdata}, {2'b10, 32'h40300004, 32'h2});
        end
        @(negedge clk);
        vectors++;
        if ({sys_wen, sys_ren, sys_addr, sys_wdata} !== {2'b00, 32'h40300004, 32'h2}) begin
            miscompares++;
            $display("FAIL write_strobe_one_cycle: got %h expected %h",
                     {sys_wen, sys_ren, sys_addr, sys_wdata}, {2'b00, 32'h40300004, 32'h2});
        end
        sys_ack   = 1'b1;
        sys_err   = 1'b0;
        sys_rdata = 32'h12345678;
        @(negedge clk);
        sys_ack = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL write_rsp: got %h expected %h",
                     {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0});
        end
        accept_rsp();
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_done: got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_read();
        push(1'b0, 32'h40350000, 32'h0);
        @(negedge clk);
        vectors++;
        if ({sys_wen, sys_ren, sys_addr} !== {2'b01, 32'h40350000}) begin
            miscompares++;
            $display("FAIL read_strobe: got %h expected %h",
                     {sys_wen, sys_ren, sys_addr}, {2'b01, 32'h40350000});
        end
        @(negedge clk);
        vectors++;
        if ({sys_ren, rsp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_wait: got %b expected 00", {sys_ren, rsp_valid});
        end
        @(negedge clk);
        sys_ack   = 1'b1;
        sys_rdata = 32'h0000000A;
        @(negedge clk);
        sys_ack = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'hA}) begin
            miscompares++;
            $display("FAIL read_rsp: got %h expected %h",
                     {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'hA});
        end
        accept_rsp();
    endtask

    task automatic test_error();
        push(1'b0, 32'h40350010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        sys_ack   = 1'b1;
        sys_err   = 1'b1;
        sys_rdata = 32'hDEADBEEF;
        @(negedge clk);
        sys_ack = 1'b0;
        sys_err = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL error_rsp: got %h expected %h",
                     {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b110, 32'hDEADBEEF});
        end
        accept_rsp();
    endtask

    task automatic test_timeout();
        int early = 0;
        int strobes = 0;
        push(1'b1, 32'h40300008, 32'h5);
        @(negedge clk);
        vectors++;
        if (sys_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_strobe: got %b expected 1", sys_wen);
        end
        sys_ack = 1'b1;
        @(negedge clk);
        sys_ack = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (rsp_valid) early++;
            if (sys_wen | sys_ren) strobes++;
            @(negedge clk);
        end
        vectors++;
        if ({early, strobes} !== 64'h0) begin
            miscompares++;
            $display("FAIL timeout_wait: got early=%0d strobes=%0d expected 0 0", early, strobes);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b101, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_rsp: got %h expected %h",
                     {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b101, 32'h0});
        end
        sys_ack   = 1'b1;
        sys_err   = 1'b1;
        sys_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        sys_ack = 1'b0;
        sys_err = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b101, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_late_ack: got %h expected %h",
                     {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b101, 32'h0});
        end
        accept_rsp();
    endtask

    task automatic test_ack_at_limit();
        push(1'b0, 32'h40350020, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_no_early_rsp: got %b expected 0", rsp_valid);
        end
        sys_ack   = 1'b1;
        sys_rdata = 32'h55;
        @(negedge clk);
        sys_ack = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h55}) begin
            miscompares++;
            $display("FAIL limit_ack_priority: got %h expected %h",
                     {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h55});
        end
        accept_rsp();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        logic [31:0] exp_rd;
        logic        exp_to;
        int steps;
        for (int i = 0; i < 6; i++) addrs[i] = 32'h40300100 + 32'(4 * i);
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = addrs[i];
            cmd_wdata = 32'h0;
            vectors++;
            if (cmd_ready !== (i < 5)) begin
                miscompares++;
                $display("FAIL b2b_accept[%0d]: got %b expected %b", i, cmd_ready, (i < 5));
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int r = 0; r < 5; r++) begin
            if (r > 0) begin
                steps = 0;
                while (!(sys_ren | sys_wen) && steps < 40) begin
                    @(negedge clk);
                    steps++;
                end
                vectors++;
                if (steps !== 1) begin
                    miscompares++;
                    $display("FAIL b2b_strobe_gap[%0d]: got %0d expected 1", r, steps);
                end
                @(negedge clk);
                sys_ack   = 1'b1;
                sys_rdata = 32'hA0 + 32'(r);
                @(negedge clk);
                sys_ack = 1'b0;
            end
            steps = 0;
            while (!rsp_valid && steps < 40) begin
                @(negedge clk);
                steps++;
            end
            exp_rd = (r == 0) ? 32'h0 : 32'hA0 + 32'(r);
            exp_to = (r == 0);
            if (r == 0) begin
                vectors++;
                if (cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_full: got %b expected 0", cmd_ready);
                end
            end
            for (int j = 0; j < 3; j++) @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_timeout, rsp_rdata, sys_addr} !== {1'b1, exp_to, exp_rd, addrs[r]}) begin
                miscompares++;
                $display("FAIL b2b_rsp[%0d]: got %h expected %h", r,
                         {rsp_valid, rsp_timeout, rsp_rdata, sys_addr}, {1'b1, exp_to, exp_rd, addrs[r]});
            end
            accept_rsp();
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drained: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        push(1'b1, 32'h40300200, 32'h11);
        push(1'b1, 32'h40300204, 32'h22);
        push(1'b1, 32'h40300208, 32'h33);
        vectors++;
        if ({busy, sys_addr} !== {1'b1, 32'h40300200}) begin
            miscompares++;
            $display("FAIL mid_pre_reset: got %h expected %h", {busy, sys_addr}, {1'b1, 32'h40300200});
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({sys_wen, sys_ren, rsp_valid, rsp_err, rsp_timeout, cmd_ready, busy,
             sys_addr, sys_wdata, rsp_rdata} !== 103'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h expected 0",
                     {sys_wen, sys_ren, rsp_valid, rsp_err, rsp_timeout, cmd_ready, busy,
                      sys_addr, sys_wdata, rsp_rdata});
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_post_release: got %b expected 10", {cmd_ready, busy});
        end
        for (int i = 0; i < 6; i++) begin
            if (sys_wen | sys_ren | rsp_valid) stray++;
            @(negedge clk);
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL mid_discarded: got %0d stray cycles expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_ack_at_limit();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
